// File: rtl/bp_be_fma_wb_scheduler.sv
//------------------------------------------------------------------------------
// bp_be_fma_wb_scheduler: issue/writeback-slot scheduler for the shared FMA pipe
// and the FP register-file writeback port (shared with the FP aux pipe).
// Optional perf counters: define BP_BE_FMA_SCHED_PERF_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bp_be_fma_wb_scheduler #(
   parameter int imul_latency_p = 4,
   parameter int fma_latency_p  = 5,
   parameter int aux_latency_p  = 2,
   parameter int starve_limit_p = 4
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        flush_i,
   input  logic        imul_v_i,
   output logic        imul_ready_o,
   input  logic        fma_v_i,
   output logic        fma_ready_o,
   input  logic        aux_v_i,
   output logic        aux_ready_o,
   output logic        pipe_v_o,
   output logic        pipe_imul_o,
   output logic        imul_wb_v_o,
   output logic        fp_wb_fma_o,
   output logic        fp_wb_aux_o,
`ifdef BP_BE_FMA_SCHED_PERF_EN
   output logic [31:0] perf_fma_stall_o,
   output logic [31:0] perf_aux_stall_o,
   output logic [31:0] perf_hold_o,
`endif
   output logic        idle_o
);

   localparam int cnt_w_lp = $clog2(starve_limit_p + 1);

   logic [fma_latency_p:1]  resv_fma_q, resv_fma_d;
   logic [fma_latency_p:1]  resv_aux_q, resv_aux_d;
   logic [imul_latency_p:1] imul_pipe_q, imul_pipe_d;
   logic                    rr_fma_q, rr_fma_d;
   logic [cnt_w_lp-1:0]     starve_q, starve_d;

   logic hold;
   logic aux_slot_free;
   logic fma_elig;
   logic imul_elig;

   always_comb begin
      hold          = (starve_q >= cnt_w_lp'(starve_limit_p));
      // Slot L after this edge's shift is what sits at bit L+1 right now.
      aux_slot_free = ~resv_fma_q[aux_latency_p+1] & ~resv_aux_q[aux_latency_p+1];

      aux_ready_o   = reset_n_i & ~flush_i & aux_v_i & aux_slot_free;
      // Nothing is ever reserved beyond fma_latency_p, so fma's slot is always open.
      fma_elig      = reset_n_i & ~flush_i & fma_v_i & ~hold;
      imul_elig     = reset_n_i & ~flush_i & imul_v_i;

      imul_ready_o  = imul_elig & (~fma_elig | ~rr_fma_q);
      fma_ready_o   = fma_elig & (~imul_elig | rr_fma_q);
      pipe_v_o      = imul_ready_o | fma_ready_o;
      pipe_imul_o   = imul_ready_o;

      imul_wb_v_o   = reset_n_i & imul_pipe_q[1];
      fp_wb_fma_o   = reset_n_i & resv_fma_q[1];
      fp_wb_aux_o   = reset_n_i & resv_aux_q[1];
      idle_o        = ~reset_n_i | ~(|resv_fma_q | |resv_aux_q | |imul_pipe_q);
   end

   always_comb begin
      resv_fma_d  = resv_fma_q >> 1;
      resv_aux_d  = resv_aux_q >> 1;
      imul_pipe_d = imul_pipe_q >> 1;
      resv_fma_d[fma_latency_p]   = fma_ready_o;
      resv_aux_d[aux_latency_p]   = resv_aux_d[aux_latency_p] | aux_ready_o;
      imul_pipe_d[imul_latency_p] = imul_ready_o;

      rr_fma_d = rr_fma_q;
      if (imul_ready_o) begin
         rr_fma_d = 1'b1;
      end else if (fma_ready_o) begin
         rr_fma_d = 1'b0;
      end

      starve_d = '0;
      if (aux_v_i && !aux_ready_o) begin
         starve_d = hold ? starve_q : starve_q + cnt_w_lp'(1);
      end

      if (flush_i) begin
         resv_fma_d  = '0;
         resv_aux_d  = '0;
         imul_pipe_d = '0;
         rr_fma_d    = 1'b0;
         starve_d    = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         resv_fma_q  <= '0;
         resv_aux_q  <= '0;
         imul_pipe_q <= '0;
         rr_fma_q    <= 1'b0;
         starve_q    <= '0;
      end else begin
         resv_fma_q  <= resv_fma_d;
         resv_aux_q  <= resv_aux_d;
         imul_pipe_q <= imul_pipe_d;
         rr_fma_q    <= rr_fma_d;
         starve_q    <= starve_d;
      end
   end

`ifdef BP_BE_FMA_SCHED_PERF_EN
   logic [31:0] perf_fma_stall_q, perf_fma_stall_d;
   logic [31:0] perf_aux_stall_q, perf_aux_stall_d;
   logic [31:0] perf_hold_q, perf_hold_d;

   // Free-running wrap-around counters; flush deliberately leaves them alone.
   always_comb begin
      perf_fma_stall_d = perf_fma_stall_q + {31'd0, fma_v_i & ~fma_ready_o};
      perf_aux_stall_d = perf_aux_stall_q + {31'd0, aux_v_i & ~aux_ready_o};
      perf_hold_d      = perf_hold_q + {31'd0, hold};
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         perf_fma_stall_q <= '0;
         perf_aux_stall_q <= '0;
         perf_hold_q      <= '0;
      end else begin
         perf_fma_stall_q <= perf_fma_stall_d;
         perf_aux_stall_q <= perf_aux_stall_d;
         perf_hold_q      <= perf_hold_d;
      end
   end

   assign perf_fma_stall_o = perf_fma_stall_q;
   assign perf_aux_stall_o = perf_aux_stall_q;
   assign perf_hold_o      = perf_hold_q;
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (!(fp_wb_fma_o && fp_wb_aux_o));
         assert (!(imul_ready_o && fma_ready_o));
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_be_fma_wb_scheduler.sv
//------------------------------------------------------------------------------
// tb_bp_be_fma_wb_scheduler: directed scenarios plus random traffic, checked
// every cycle against an absolute-time writeback-calendar model.
//------------------------------------------------------------------------------
`default_nettype none

module tb_bp_be_fma_wb_scheduler;

   localparam int IL = 4;
   localparam int FL = 5;
   localparam int AL = 2;
   localparam int SL = 4;
   localparam int DEPTH = 4096;

   logic clk = 1'b1;
   logic reset_n = 1'b0, flush = 1'b0, imul_v = 1'b0, fma_v = 1'b0, aux_v = 1'b0;
   logic imul_ready, fma_ready, aux_ready, pipe_v, pipe_imul;
   logic imul_wb_v, fp_wb_fma, fp_wb_aux, idle;
`ifdef BP_BE_FMA_SCHED_PERF_EN
   logic [31:0] perf_fma_stall, perf_aux_stall, perf_hold;
`endif

   bp_be_fma_wb_scheduler #(
      .imul_latency_p(IL), .fma_latency_p(FL), .aux_latency_p(AL), .starve_limit_p(SL)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
      .imul_v_i(imul_v), .imul_ready_o(imul_ready),
      .fma_v_i(fma_v), .fma_ready_o(fma_ready),
      .aux_v_i(aux_v), .aux_ready_o(aux_ready),
      .pipe_v_o(pipe_v), .pipe_imul_o(pipe_imul),
      .imul_wb_v_o(imul_wb_v), .fp_wb_fma_o(fp_wb_fma), .fp_wb_aux_o(fp_wb_aux),
`ifdef BP_BE_FMA_SCHED_PERF_EN
      .perf_fma_stall_o(perf_fma_stall), .perf_aux_stall_o(perf_aux_stall),
      .perf_hold_o(perf_hold),
`endif
      .idle_o(idle)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Model: which absolute cycle each kind of writeback lands on.
   bit m_fma [0:DEPTH-1];
   bit m_aux [0:DEPTH-1];
   bit m_imul[0:DEPTH-1];
   bit m_rr_fma = 1'b0;
   int m_starve = 0;
   logic [31:0] m_pfs = 0, m_pas = 0, m_ph = 0;

   bit rec_imul[0:DEPTH-1], rec_fma[0:DEPTH-1], rec_aux[0:DEPTH-1];
   bit rec_iwb[0:DEPTH-1], rec_fwb[0:DEPTH-1], rec_awb[0:DEPTH-1], rec_idle[0:DEPTH-1];

   task automatic chk(input string name, input int c, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0d expected %0d", name, c, got, exp);
      end
   endtask

   always @(negedge clk) begin
      bit hold, fe, ie, e_i, e_f, e_a, e_idle;
      hold = (m_starve >= SL);
      e_i = 0; e_f = 0; e_a = 0;
      if (reset_n) begin
         e_a = aux_v && !flush && !m_fma[cyc+AL] && !m_aux[cyc+AL];
         fe  = fma_v && !flush && !hold && !m_fma[cyc+FL] && !m_aux[cyc+FL];
         ie  = imul_v && !flush;
         e_i = ie && (!fe || !m_rr_fma);
         e_f = fe && (!ie || m_rr_fma);
      end
      e_idle = 1;
      for (int k = 0; k <= FL; k++)
         if (m_fma[cyc+k] || m_aux[cyc+k] || m_imul[cyc+k]) e_idle = 0;
      if (!reset_n) e_idle = 1;

      chk("imul_ready", cyc, imul_ready, e_i);
      chk("fma_ready", cyc, fma_ready, e_f);
      chk("aux_ready", cyc, aux_ready, e_a);
      chk("pipe_v", cyc, pipe_v, e_i | e_f);
      chk("pipe_imul", cyc, pipe_imul, e_i);
      chk("imul_wb_v", cyc, imul_wb_v, reset_n & m_imul[cyc]);
      chk("fp_wb_fma", cyc, fp_wb_fma, reset_n & m_fma[cyc]);
      chk("fp_wb_aux", cyc, fp_wb_aux, reset_n & m_aux[cyc]);
      chk("idle", cyc, idle, e_idle);
`ifdef BP_BE_FMA_SCHED_PERF_EN
      if (reset_n) begin
         chk("perf_fma_stall", cyc, perf_fma_stall, m_pfs);
         chk("perf_aux_stall", cyc, perf_aux_stall, m_pas);
         chk("perf_hold", cyc, perf_hold, m_ph);
      end
`endif
      rec_imul[cyc] = imul_ready; rec_fma[cyc] = fma_ready; rec_aux[cyc] = aux_ready;
      rec_iwb[cyc] = imul_wb_v; rec_fwb[cyc] = fp_wb_fma; rec_awb[cyc] = fp_wb_aux;
      rec_idle[cyc] = idle;

      if (!reset_n || flush) begin
         for (int k = 1; k <= FL + 1; k++) begin
            m_fma[cyc+k] = 0; m_aux[cyc+k] = 0; m_imul[cyc+k] = 0;
         end
         m_rr_fma = 0;
         m_starve = 0;
      end else begin
         if (e_f) m_fma[cyc+FL] = 1;
         if (e_a) m_aux[cyc+AL] = 1;
         if (e_i) m_imul[cyc+IL] = 1;
         if (e_i) m_rr_fma = 1;
         else if (e_f) m_rr_fma = 0;
         m_starve = (aux_v && !e_a) ? ((m_starve + 1 > SL) ? SL : m_starve + 1) : 0;
      end
      if (!reset_n) begin
         m_pfs = 0; m_pas = 0; m_ph = 0;
      end else begin
         m_pfs = m_pfs + ((fma_v && !e_f) ? 1 : 0);
         m_pas = m_pas + ((aux_v && !e_a) ? 1 : 0);
         m_ph  = m_ph + (hold ? 1 : 0);
      end
      cyc++;
   end

   task automatic drive(input logic r, input logic f, input logic i, input logic m,
                        input logic a);
      reset_n = r; flush = f; imul_v = i; fma_v = m; aux_v = a;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int s;
      // Reset with every request raised, then imul/fma contention.
      repeat (3) drive(0, 0, 1, 1, 1);
      for (int c = 0; c < 3; c++) begin
         chk("rst_idle", c, rec_idle[c], 1);
         chk("rst_no_grant", c, rec_imul[c] | rec_fma[c] | rec_aux[c], 0);
      end
      s = cyc;
      repeat (6) drive(1, 0, 1, 1, 0);
      repeat (7) drive(1, 0, 0, 0, 0);
      for (int k = 0; k < 6; k++) begin
         chk("alt_imul", s + k, rec_imul[s+k], (k % 2 == 0) ? 1 : 0);
         chk("alt_fma", s + k, rec_fma[s+k], (k % 2 == 1) ? 1 : 0);
         chk("imul_wb_lat", s + 4 + k, rec_iwb[s+4+k], (k % 2 == 0) ? 1 : 0);
         chk("fma_wb_lat", s + 6 + k, rec_fwb[s+6+k], (k % 2 == 0) ? 1 : 0);
      end

      // Aux collides with an in-flight fma slot.
      s = cyc;
      drive(1, 0, 0, 1, 0);
      repeat (2) drive(1, 0, 0, 0, 0);
      repeat (2) drive(1, 0, 0, 0, 1);
      repeat (4) drive(1, 0, 0, 0, 0);
      chk("s3_fma_grant", s, rec_fma[s], 1);
      chk("s3_aux_deny", s + 3, rec_aux[s+3], 0);
      chk("s3_aux_grant", s + 4, rec_aux[s+4], 1);
      chk("s3_fma_wb", s + 5, rec_fwb[s+5], 1);
      chk("s3_aux_wb", s + 6, rec_awb[s+6], 1);

      // Continuous fma + aux: starvation hold kicks in.
      s = cyc;
      repeat (14) drive(1, 0, 0, 1, 1);
      repeat (8) drive(1, 0, 0, 0, 0);
      chk("s4_aux_early", s + 2, rec_aux[s+2], 1);
      chk("s4_aux_deny", s + 3, rec_aux[s+3], 0);
      chk("s4_fma_last", s + 6, rec_fma[s+6], 1);
      chk("s4_fma_held", s + 7, rec_fma[s+7], 0);
      chk("s4_aux_deny9", s + 9, rec_aux[s+9], 0);
      chk("s4_fma_held10", s + 10, rec_fma[s+10], 0);
      chk("s4_aux_grant", s + 10, rec_aux[s+10], 1);
      chk("s4_fma_resume", s + 11, rec_fma[s+11], 1);

      // Flush with three fma ops in flight.
      s = cyc;
      repeat (3) drive(1, 0, 0, 1, 0);
      drive(1, 1, 1, 1, 1);
      repeat (8) drive(1, 0, 0, 0, 0);
      chk("s5_flush_grants", s + 3, rec_imul[s+3] | rec_fma[s+3] | rec_aux[s+3], 0);
      chk("s5_idle_after", s + 4, rec_idle[s+4], 1);
      for (int k = 4; k <= 10; k++) chk("s5_no_fma_wb", s + k, rec_fwb[s+k], 0);

      // Random traffic with occasional flush and reset.
      for (int n = 0; n < 600; n++) begin
         drive(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
      end
      drive(1, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
